shift_add_mac: RTL and testbench

SHIFT_ADD_MAC -- requirements
Module: shift_add_mac

---
 rtl/shift_add_mac.sv | 145 ++++++++++++++
 tb/tb_shift_add_mac.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mac.sv
// Shift-add multiply-accumulate: two product stages feeding a NUM_TAPS-term sum.
// Define SHIFT_ADD_MAC_SATURATE_EN to clamp the sum to the output range.
module shift_add_mac #(
    parameter int DATA_W   = 8,
    parameter int NUM_TAPS = 4,
    parameter int OUT_W    = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic [2:0]                    select_line,
    input  logic [1:0]                    i_shifter_count,
    input  logic                          polynomial_zero,
    input  logic                          select_line_vld,
    input  logic                          sum_clear,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_vld,
    output logic [$clog2(NUM_TAPS)-1:0]   tap_index
);

    localparam int PW    = DATA_W + 4;
    localparam int TW    = $clog2(NUM_TAPS);
    localparam int ACC_W = PW + TW;
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    typedef struct packed {
        logic                 vld;
        logic                 zero;
        logic [1:0]           shift;
        logic signed [PW-1:0] odd;
    } s1_t;

    typedef struct packed {
        logic                 vld;
        logic signed [PW-1:0] prod;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic [TW-1:0]           tap_d, tap_q;
    logic signed [OUT_W-1:0] out_d, out_q;
    logic                    vld_d, vld_q;

    logic signed [PW-1:0]    x_ext;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [OUT_W-1:0] reduced;
    logic                    last_tap;

    // Odd coefficient {select_line,1} realised as sum of shifted copies.
    always_comb begin
        x_ext = PW'(in_data);
        s1_d.vld   = select_line_vld;
        s1_d.zero  = polynomial_zero;
        s1_d.shift = i_shifter_count;
        s1_d.odd   = x_ext
                   + (select_line[0] ? (x_ext <<< 1) : '0)
                   + (select_line[1] ? (x_ext <<< 2) : '0)
                   + (select_line[2] ? (x_ext <<< 3) : '0);
    end

    always_comb begin
        s2_d.vld  = s1_q.vld;
        s2_d.prod = s1_q.zero ? '0 : (s1_q.odd <<< s1_q.shift);
    end

    always_comb begin
        prod_ext = ACC_W'(s2_q.prod);
        acc_sum  = acc_q + prod_ext;
        last_tap = (tap_q == TW'(NUM_TAPS - 1));
    end

`ifdef SHIFT_ADD_MAC_SATURATE_EN
    localparam logic signed [EXT_W-1:0] OMAX =
        EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] OMIN = -OMAX - 1;

    logic signed [EXT_W-1:0] sum_ext;

    always_comb begin
        sum_ext = EXT_W'(acc_sum);
        if (sum_ext > OMAX) begin
            reduced = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (sum_ext < OMIN) begin
            reduced = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            reduced = OUT_W'(sum_ext);
        end
    end
`else
    always_comb begin
        reduced = OUT_W'(acc_sum);
    end
`endif

    // A clear that meets a valid product restarts the sum with that product.
    always_comb begin
        acc_d = acc_q;
        tap_d = tap_q;
        out_d = out_q;
        vld_d = 1'b0;
        if (sum_clear && s2_q.vld) begin
            acc_d = prod_ext;
            tap_d = TW'(1);
        end else if (sum_clear) begin
            acc_d = '0;
            tap_d = '0;
        end else if (s2_q.vld) begin
            if (last_tap) begin
                out_d = reduced;
                vld_d = 1'b1;
                acc_d = '0;
                tap_d = '0;
            end else begin
                acc_d = acc_sum;
                tap_d = tap_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            acc_q <= '0;
            tap_q <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            acc_q <= acc_d;
            tap_q <= tap_d;
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign out_data  = out_q;
    assign out_vld   = vld_q;
    assign tap_index = tap_q;

endmodule

// File: tb/tb_shift_add_mac.sv
// Directed-vector bench for shift_add_mac at default parameters.
// Expected sums are hand-computed from the coefficient decode.
module tb_shift_add_mac;

    logic              clk;
    logic              reset;
    logic signed [7:0] in_data;
    logic [2:0]        select_line;
    logic [1:0]        i_shifter_count;
    logic              polynomial_zero;
    logic              select_line_vld;
    logic              sum_clear;
    logic [11:0]       out_data;
    logic              out_vld;
    logic [1:0]        tap_index;

    int nchk;
    int nerr;

    shift_add_mac dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .select_line     (select_line),
        .i_shifter_count (i_shifter_count),
        .polynomial_zero (polynomial_zero),
        .select_line_vld (select_line_vld),
        .sum_clear       (sum_clear),
        .out_data        (out_data),
        .out_vld         (out_vld),
        .tap_index       (tap_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after a falling edge and are sampled on the next rise.
    task automatic tap(input logic signed [7:0] d, input logic [2:0] sel,
                       input logic [1:0] sh, input logic z);
        in_data         = d;
        select_line     = sel;
        i_shifter_count = sh;
        polynomial_zero = z;
        select_line_vld = 1'b1;
        @(negedge clk);
        select_line_vld = 1'b0;
    endtask

    task automatic idle();
        select_line_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic taps4(input logic signed [7:0] d, input logic [2:0] sel,
                         input logic [1:0] sh);
        for (int i = 0; i < 4; i++) begin
            tap(d, sel, sh, 1'b0);
            check("no_early_vld", {31'd0, out_vld}, 32'd0);
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        reset           = 1'b0;
        in_data         = '0;
        select_line     = '0;
        i_shifter_count = '0;
        polynomial_zero = 1'b0;
        select_line_vld = 1'b0;
        sum_clear       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_data", {20'd0, out_data}, 32'd0);
        check("rst_out_vld", {31'd0, out_vld}, 32'd0);
        check("rst_tap_index", {30'd0, tap_index}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 10 * 6 four times = 240, out 3 edges after the last tap.
        taps4(8'sd10, 3'b001, 2'd1);
        check("c6_tap_after4", {30'd0, tap_index}, 32'd2);
        idle();
        check("c6_vld_lat2", {31'd0, out_vld}, 32'd0);
        check("c6_tap_lat2", {30'd0, tap_index}, 32'd3);
        idle();
        check("c6_vld", {31'd0, out_vld}, 32'd1);
        check("c6_data", {20'd0, out_data}, 32'd240);
        check("c6_tap_wrap", {30'd0, tap_index}, 32'd0);
        idle();
        check("c6_vld_pulse", {31'd0, out_vld}, 32'd0);
        check("c6_data_hold", {20'd0, out_data}, 32'd240);

        // 5*1 + 0 + 5*8 + 5*2 = 55
        tap(8'sd5, 3'b000, 2'd0, 1'b0);
        tap(8'sd5, 3'b101, 2'd2, 1'b1);
        tap(8'sd5, 3'b000, 2'd3, 1'b0);
        check("mix_tap1", {30'd0, tap_index}, 32'd1);
        tap(8'sd5, 3'b000, 2'd1, 1'b0);
        check("mix_tap2", {30'd0, tap_index}, 32'd2);
        idle();
        check("mix_tap3", {30'd0, tap_index}, 32'd3);
        idle();
        check("mix_vld", {31'd0, out_vld}, 32'd1);
        check("mix_data", {20'd0, out_data}, 32'd55);
        check("mix_tap0", {30'd0, tap_index}, 32'd0);
        idle();

        // 127*15*4 = 7620 = 0x1DC4
        taps4(8'sd127, 3'b111, 2'd0);
        idle();
        idle();
        check("pos_vld", {31'd0, out_vld}, 32'd1);
`ifdef SHIFT_ADD_MAC_SATURATE_EN
        check("pos_data", {20'd0, out_data}, 32'h7FF);
`else
        check("pos_data", {20'd0, out_data}, 32'hDC4);
`endif
        idle();

        // -128*15*4 = -7680, low 12 bits 0x200
        taps4(-8'sd128, 3'b111, 2'd0);
        idle();
        idle();
        check("neg_vld", {31'd0, out_vld}, 32'd1);
`ifdef SHIFT_ADD_MAC_SATURATE_EN
        check("neg_data", {20'd0, out_data}, 32'h800);
`else
        check("neg_data", {20'd0, out_data}, 32'h200);
`endif
        idle();

        // Clear meeting the third product: sum restarts at 10, then +30 = 40.
        tap(8'sd10, 3'b000, 2'd0, 1'b0);
        tap(8'sd10, 3'b000, 2'd0, 1'b0);
        tap(8'sd10, 3'b000, 2'd0, 1'b0);
        idle();
        check("clr_tap_before", {30'd0, tap_index}, 32'd2);
        sum_clear = 1'b1;
        idle();
        sum_clear = 1'b0;
        check("clr_tap_restart", {30'd0, tap_index}, 32'd1);
        check("clr_no_vld", {31'd0, out_vld}, 32'd0);
        tap(8'sd10, 3'b000, 2'd0, 1'b0);
        tap(8'sd10, 3'b000, 2'd0, 1'b0);
        tap(8'sd10, 3'b000, 2'd0, 1'b0);
        check("clr_no_early", {31'd0, out_vld}, 32'd0);
        idle();
        check("clr_no_early2", {31'd0, out_vld}, 32'd0);
        idle();
        check("clr_vld", {31'd0, out_vld}, 32'd1);
        check("clr_data", {20'd0, out_data}, 32'd40);
        idle();

        // Clear with an empty pipeline drops a partial sum of 14.
        tap(8'sd7, 3'b000, 2'd0, 1'b0);
        tap(8'sd7, 3'b000, 2'd0, 1'b0);
        idle();
        idle();
        check("iclr_tap_before", {30'd0, tap_index}, 32'd2);
        sum_clear = 1'b1;
        idle();
        sum_clear = 1'b0;
        check("iclr_tap_zero", {30'd0, tap_index}, 32'd0);
        taps4(8'sd3, 3'b000, 2'd0);
        idle();
        idle();
        check("iclr_vld", {31'd0, out_vld}, 32'd1);
        check("iclr_data", {20'd0, out_data}, 32'd12);
        idle();

        // Reset mid-sum: in-flight taps lost, next sum starts fresh.
        tap(8'sd9, 3'b000, 2'd0, 1'b0);
        tap(8'sd9, 3'b000, 2'd0, 1'b0);
        reset = 1'b0;
        #1;
        check("mrst_out_data", {20'd0, out_data}, 32'd0);
        check("mrst_out_vld", {31'd0, out_vld}, 32'd0);
        check("mrst_tap_index", {30'd0, tap_index}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        taps4(8'sd1, 3'b000, 2'd0);
        check("mrst_tap2", {30'd0, tap_index}, 32'd2);
        idle();
        check("mrst_no_early", {31'd0, out_vld}, 32'd0);
        idle();
        check("mrst_vld", {31'd0, out_vld}, 32'd1);
        check("mrst_data", {20'd0, out_data}, 32'd4);
        idle();
        check("mrst_vld_low", {31'd0, out_vld}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
